// File: rtl/pos_add_digit.sv
// Gate-level ripple adder for one N_DIGIT-bit digit; purely combinational (zero latency).
// No handshake: the sequencer decides when the sum is captured.
module pos_add_digit #(
    parameter int N_DIGIT = 4
) (
    input  logic [N_DIGIT-1:0] a,
    input  logic [N_DIGIT-1:0] b,
    input  logic               cin,
    output wire  [N_DIGIT-1:0] sum,
    output wire                cout
);

    wire [N_DIGIT:0]   cy;
    wire [N_DIGIT-1:0] p;
    wire [N_DIGIT-1:0] g;
    wire [N_DIGIT-1:0] t;

    assign cy[0] = cin;

    for (genvar k = 0; k < N_DIGIT; k++) begin : g_bit
        xor u_p   (p[k], a[k], b[k]);
        xor u_s   (sum[k], p[k], cy[k]);
        and u_g   (g[k], a[k], b[k]);
        and u_t   (t[k], p[k], cy[k]);
        or  u_c   (cy[k+1], g[k], t[k]);
    end

    assign cout = cy[N_DIGIT];

endmodule

// File: rtl/seq_pos_add.sv
// Digit-serial unsigned adder c = a + b: N_DIG cycles from accept to out_valid, one op in flight.
// in_ready only in IDLE; result and out_valid hold until out_ready.
module seq_pos_add #(
    parameter int N_BITS_L = 8,
    parameter int N_BITS_R = 8,
    parameter int N_DIGIT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS_L-1:0] a,
    input  logic [N_BITS_R-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS_L:0]   c
);

    localparam int N_DIG   = (N_BITS_L + N_DIGIT - 1) / N_DIGIT;
    localparam int CNT_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int W_PAD   = N_DIG * N_DIGIT;
    localparam int TOP_OFF = N_BITS_L - (N_DIG - 1) * N_DIGIT;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIG - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [W_PAD-1:0]  a_sh;
    logic [W_PAD-1:0]  b_sh;
    logic              carry;
    logic [CNT_W-1:0]  cnt;
    logic [N_BITS_L:0] c_reg;
    logic              last;
    wire [N_DIGIT-1:0] dsum;
    wire               dcout;
    wire               top_bit;

    pos_add_digit #(.N_DIGIT(N_DIGIT)) u_digit (
        .a    (a_sh[N_DIGIT-1:0]),
        .b    (b_sh[N_DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    // With a zero-padded top digit the carry into bit N_BITS_L lands inside that digit's sum.
    if (TOP_OFF == N_DIGIT) begin : g_top_cout
        assign top_bit = dcout;
    end else begin : g_top_pad
        assign top_bit = dsum[TOP_OFF];
    end

    assign last = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            c_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= W_PAD'(a);
                        b_sh  <= W_PAD'(b);
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> N_DIGIT;
                    b_sh  <= b_sh >> N_DIGIT;
                    carry <= dcout;
                    cnt   <= cnt + 1'b1;
                    for (int i = 0; i < N_BITS_L; i++) begin
                        if (cnt == CNT_W'(i / N_DIGIT)) c_reg[i] <= dsum[i % N_DIGIT];
                    end
                    if (last) c_reg[N_BITS_L] <= top_bit;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign c         = c_reg;

endmodule
